// File: rtl/spi_reg_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_master_if
//  Description : Core-side command/response bundle for spi_reg_master.
//                master modport - the core issuing register commands
//                slave  modport - the SPI controller executing them
//  Signals     : cmd_valid/cmd_ready   command handshake
//                cmd_write             1 = write, 0 = read
//                cmd_addr  [ADDR_W]    register address
//                cmd_wdata [REG_W]     write data
//                rsp_valid             single-cycle end-of-transfer strobe
//                rsp_rdata [REG_W]     data captured during the data phase
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_master_if #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [REG_W-1:0]  cmd_wdata;
  logic              rsp_valid;
  logic [REG_W-1:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_master
//  Description : SPI controller producing the spi_reg register-access frame.
//                One accepted command becomes one CS-framed transfer of
//                8+REG_W bits, MSB first: {write, zero pad, addr} then data
//                (write data, or zeros for reads). The last REG_W bits
//                sampled are returned on a one-cycle response strobe.
//  Parameters  : ADDR_W  (1..7) address width
//                REG_W           register data width
//                CLK_DIV (>=1)   clk cycles per SPI half-period
//  Ports       : clk, rst        clock, synchronous active-high reset
//                ena_i           gates command acceptance only
//                mode_i[1:0]     {CPOL,CPHA}, latched at acceptance
//                cmd_if          command/response bundle (slave modport)
//                spi_cs_n_o      chip select, active low
//                spi_clk_o       SPI clock
//                spi_mosi_o      controller-out data
//                spi_miso_i      controller-in data
//                loopback_i      only with SPI_MASTER_LOOPBACK_EN: receive
//                                from internal MOSI instead of spi_miso_i
//  Option      : `define SPI_MASTER_LOOPBACK_EN adds loopback_i
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_master #(
  parameter int ADDR_W  = 4,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena_i,
  input  logic [1:0]      mode_i,
  spi_reg_master_if.slave cmd_if,
  output logic            spi_cs_n_o,
  output logic            spi_clk_o,
  output logic            spi_mosi_o,
  input  logic            spi_miso_i
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic            loopback_i
`endif
);

  localparam int FRAME_W = 8 + REG_W;
  localparam int EDGES   = 2 * FRAME_W;
  localparam int EDGE_W  = $clog2(EDGES);
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  HP_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [REG_W-1:0]     rx_q, rx_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [REG_W-1:0]     rdata_q, rdata_d;
  logic                 lpbk_q, lpbk_d;

  logic                 w_accept;
  logic                 w_hp_end;
  logic                 w_fire;
  logic [EDGE_W-1:0]    w_idx;
  logic                 w_rx_bit;
  logic                 w_lpbk_in;
  logic [7:0]           w_cmd_byte;
  logic [FRAME_W-1:0]   w_frame;
  logic [REG_W:0]       w_rx_ext;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_lpbk_in = loopback_i;
  // Loopback reads the MOSI pin register, i.e. exactly what the slave sees.
  assign w_rx_bit  = lpbk_q ? mosi_q : spi_miso_i;
`else
  assign w_lpbk_in = 1'b0;
  assign w_rx_bit  = spi_miso_i;
`endif

  assign w_accept = cmd_if.cmd_valid & ready_q;
  assign w_hp_end = (cnt_q == HP_LAST);
  assign w_rx_ext = {rx_q, w_rx_bit};

  always_comb begin
    w_cmd_byte                = '0;
    w_cmd_byte[7]             = cmd_if.cmd_write;
    w_cmd_byte[ADDR_W-1:0]    = cmd_if.cmd_addr;
    w_frame = {w_cmd_byte, (cmd_if.cmd_write ? cmd_if.cmd_wdata : {REG_W{1'b0}})};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = w_hp_end ? '0 : cnt_q + 1'b1;
    edge_d      = edge_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    lpbk_d      = lpbk_q;
    w_fire      = 1'b0;
    w_idx       = edge_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (w_accept) begin
          state_d = ST_SETUP;
          cpol_d  = mode_i[1];
          cpha_d  = mode_i[0];
          lpbk_d  = w_lpbk_in;
          sclk_d  = mode_i[1];
          edge_d  = '0;
          rx_d    = '0;
          // CPHA=0 presents the MSB during SETUP, so the shifter starts one
          // bit ahead; CPHA=1 drives the MSB on the first leading edge.
          if (mode_i[0]) begin
            tx_d   = w_frame;
            mosi_d = 1'b0;
          end else begin
            tx_d   = {w_frame[FRAME_W-2:0], 1'b0};
            mosi_d = w_frame[FRAME_W-1];
          end
        end
      end
      ST_SETUP: begin
        if (w_hp_end) begin
          state_d = ST_SHIFT;
          w_fire  = 1'b1;
          w_idx   = '0;
          edge_d  = '0;
        end
      end
      ST_SHIFT: begin
        // edge_q holds the index of the last SPI edge produced; the edge
        // count closes the phase so SHIFT spans exactly 2*FRAME_W halves.
        if (w_hp_end) begin
          if (edge_q == EDGE_LAST) begin
            state_d = ST_HOLD;
          end else begin
            w_fire = 1'b1;
            w_idx  = edge_q + 1'b1;
            edge_d = edge_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_hp_end) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rdata_d     = rx_q;
        end
        if (w_hp_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Even edge index = leading edge. The sampling edge is leading for
    // CPHA=0 and trailing for CPHA=1; the other edge drives MOSI.
    if (w_fire) begin
      sclk_d = ~sclk_q;
      if (~w_idx[0] ^ cpha_q) begin
        rx_d = w_rx_ext[REG_W-1:0];
      end else begin
        mosi_d = tx_q[FRAME_W-1];
        tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
      end
    end

    if (state_d == ST_IDLE) begin
      sclk_d = mode_i[1];
      mosi_d = 1'b0;
    end
    if (state_d == ST_GAP) mosi_d = 1'b0;
  end

  assign cs_n_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
  assign ready_d = (state_d == ST_IDLE) && ena_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      lpbk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      lpbk_q      <= lpbk_d;
    end
  end

  assign cmd_if.cmd_ready = ready_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_rdata = rdata_q;
  assign spi_cs_n_o       = cs_n_q;
  assign spi_clk_o        = sclk_q;
  assign spi_mosi_o       = mosi_q;

endmodule
`default_nettype wire
